// File: rtl/pokey_aud_channel.sv
// POKEY-style audio channel: programmable divider with borrow output, a poly-gated tone
// flip-flop, and a registered volume sample.
module pokey_aud_channel #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 cnt_en,
    input  logic [CNT_WIDTH-1:0] audf,
    input  logic [7:0]           audc,
    input  logic                 stimer,
    input  logic                 poly4bit,
    input  logic                 poly5bit,
    input  logic                 poly917bit,
    output logic                 tone,
    output logic                 borrow,
    output logic [3:0]           aud_out
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tone_q, tone_d;
    logic                 borrow_q, borrow_d;
    logic [3:0]           aud_q, aud_d;
    logic                 tick_s;
    logic                 underflow_s;

    assign tick_s      = enable & cnt_en;
    assign underflow_s = tick_s && (cnt_q == {CNT_WIDTH{1'b0}});

    // Tone source selected at underflow; the 5-bit poly gate can freeze the flip-flop.
    function automatic logic next_tone(input logic [7:0] ctl, input logic cur,
                                       input logic p4, input logic p5, input logic p917);
        logic res;
        if (!ctl[7] && !p5) begin
            res = cur;
        end else if (ctl[5]) begin
            res = ~cur;
        end else if (ctl[6]) begin
            res = p4;
        end else begin
            res = p917;
        end
        return res;
    endfunction

    // Next-state: stimer restarts the divider ahead of any coincident tick.
    always_comb begin
        cnt_d    = cnt_q;
        tone_d   = tone_q;
        borrow_d = 1'b0;
        if (stimer) begin
            cnt_d  = audf;
            tone_d = 1'b0;
        end else if (underflow_s) begin
            cnt_d    = audf;
            borrow_d = 1'b1;
            tone_d   = next_tone(audc, tone_q, poly4bit, poly5bit, poly917bit);
        end else if (tick_s) begin
            cnt_d = cnt_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        // Volume follows the tone value being loaded on this same edge.
        if (audc[4] || tone_d) begin
            aud_d = audc[3:0];
        end else begin
            aud_d = 4'h0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= {CNT_WIDTH{1'b0}};
            tone_q   <= 1'b0;
            borrow_q <= 1'b0;
            aud_q    <= 4'h0;
        end else begin
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            borrow_q <= borrow_d;
            aud_q    <= aud_d;
        end
    end

    assign tone    = tone_q;
    assign borrow  = borrow_q;
    assign aud_out = aud_q;

endmodule

// File: tb/tb_pokey_aud_channel.sv
// Directed bench for pokey_aud_channel with hand-computed expectations.
module tb_pokey_aud_channel;

    logic       clk = 1'b0;
    logic       reset_n, enable, cnt_en, stimer;
    logic [7:0] audf, audc;
    logic       poly4bit, poly5bit, poly917bit;
    logic       tone, borrow;
    logic [3:0] aud_out;

    int n_total = 0;
    int n_bad   = 0;

    always #10 clk = ~clk;

    pokey_aud_channel #(.CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cnt_en(cnt_en),
        .audf(audf), .audc(audc), .stimer(stimer),
        .poly4bit(poly4bit), .poly5bit(poly5bit), .poly917bit(poly917bit),
        .tone(tone), .borrow(borrow), .aud_out(aud_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic t, input logic b, input logic [3:0] a);
        check({tag, ".tone"}, {31'd0, tone}, {31'd0, t});
        check({tag, ".borrow"}, {31'd0, borrow}, {31'd0, b});
        check({tag, ".aud"}, {28'd0, aud_out}, {28'd0, a});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    task automatic do_stimer();
        stimer = 1'b1;
        step();
        stimer = 1'b0;
    endtask

    initial begin
        int seq4 [4];
        int seq9 [3];
        logic t;
        seq4 = '{1, 0, 0, 1};
        seq9 = '{1, 1, 0};

        reset_n = 1'b0; enable = 1'b1; cnt_en = 1'b1; stimer = 1'b0;
        audf = 8'h03; audc = 8'hA8;
        poly4bit = 1'b0; poly5bit = 1'b0; poly917bit = 1'b0;
        step(); step();
        check_out("reset", 1'b0, 1'b0, 4'h0);

        // Divide-by-4 pure tone, volume 8.
        reset_n = 1'b1; enable = 1'b0;
        step();
        check_out("idle", 1'b0, 1'b0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            t = ((k / 4) % 2) == 0;
            do_tick();
            check_out($sformatf("A.t%0d", k), t, (k % 4) == 0, t ? 4'h8 : 4'h0);
            step();
            check("A.brw_one", {31'd0, borrow}, 32'd0);
        end
        step(); step(); step();
        check("A.noen_tone", {31'd0, tone}, 32'd0);
        do_tick();
        check_out("A.t8", 1'b1, 1'b1, 4'h8);
        step();
        cnt_en = 1'b0; enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("A.cnten0", {31'd0, borrow}, 32'd0);
        end
        cnt_en = 1'b1; enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_tick();
            check_out("A.mid", 1'b1, 1'b0, 4'h8);
        end
        do_tick();
        check_out("A.t12", 1'b0, 1'b1, 4'h0);

        // audf=0: underflow on every tick.
        audf = 8'h00; audc = 8'hAF;
        do_stimer();
        check_out("B.stim", 1'b0, 1'b0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            t = (k % 2) == 0;
            do_tick();
            check_out($sformatf("B.t%0d", k), t, 1'b1, t ? 4'hF : 4'h0);
            step();
            check("B.brw_one", {31'd0, borrow}, 32'd0);
        end

        // Volume-only.
        audc = 8'h15;
        step();
        check("C.vol", {28'd0, aud_out}, 32'd5);
        for (int k = 0; k < 4; k++) begin
            poly4bit = k[0]; poly5bit = k[1]; poly917bit = ~k[0];
            do_tick();
            check("C.vol_tick", {28'd0, aud_out}, 32'd5);
        end

        // 4-bit poly select, then 9/17-bit select.
        audc = 8'hC6; poly5bit = 1'b0;
        do_stimer();
        check_out("D.stim", 1'b0, 1'b0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            poly4bit = seq4[k][0]; poly917bit = ~seq4[k][0];
            do_tick();
            check_out($sformatf("D.p4_%0d", k), seq4[k][0], 1'b1, seq4[k][0] ? 4'h6 : 4'h0);
        end
        audc = 8'h86;
        for (int k = 0; k < 3; k++) begin
            poly917bit = seq9[k][0]; poly4bit = ~seq9[k][0];
            do_tick();
            check($sformatf("D.p917_%0d", k), {31'd0, tone}, {31'd0, seq9[k][0]});
        end

        // 5-bit gate holds tone until poly5bit=1.
        audc = 8'h26;
        do_stimer();
        check("E.stim", {31'd0, tone}, 32'd0);
        poly5bit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_tick();
            check_out("E.gated", 1'b0, 1'b1, 4'h0);
        end
        poly5bit = 1'b1;
        do_tick();
        check_out("E.open1", 1'b1, 1'b1, 4'h6);
        do_tick();
        check_out("E.open2", 1'b0, 1'b1, 4'h0);

        // stimer beats coincident underflow tick; new audf mid-count waits for reload.
        audf = 8'h10; audc = 8'hA8;
        stimer = 1'b1; enable = 1'b1;
        step();
        stimer = 1'b0; enable = 1'b0;
        check_out("F.stim_prio", 1'b0, 1'b0, 4'h0);
        audf = 8'h02;
        for (int k = 1; k <= 16; k++) begin
            do_tick();
            check($sformatf("F.cnt%0d", k), {31'd0, borrow}, 32'd0);
        end
        do_tick();
        check_out("F.t17", 1'b1, 1'b1, 4'h8);
        do_tick();
        check("F.r1", {31'd0, borrow}, 32'd0);
        do_tick();
        check("F.r2", {31'd0, borrow}, 32'd0);
        do_tick();
        check_out("F.r3", 1'b0, 1'b1, 4'h0);
        do_tick();

        // Reset mid-count with coincident stimer and tick.
        audc = 8'h15;
        step();
        check("G.pre", {28'd0, aud_out}, 32'd5);
        reset_n = 1'b0; stimer = 1'b1; enable = 1'b1;
        step();
        check_out("G.rst", 1'b0, 1'b0, 4'h0);
        reset_n = 1'b1; stimer = 1'b0; enable = 1'b0;
        audf = 8'h03; audc = 8'hA8;
        step();
        do_tick();
        check_out("G.first", 1'b1, 1'b1, 4'h8);
        for (int k = 0; k < 3; k++) begin
            do_tick();
            check("G.cnt", {31'd0, borrow}, 32'd0);
        end
        do_tick();
        check_out("G.second", 1'b0, 1'b1, 4'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
